// File: rtl/display_scan_driver.sv
// Time-multiplexed digit scanner feeding seven_segs_decoder: frame-stable shadow, guard cycle, per-digit blink.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits at shadow load.
module display_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [5*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    output logic [4:0]                digit_code,
    output logic [NUM_DIGITS-1:0]     an_n,
    output logic                      frame_start
);

    localparam int unsigned CODE_W = 5;
    localparam int unsigned CW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW     = $clog2(NUM_DIGITS);
    localparam int unsigned FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CODE_W-1:0] BLANK = 5'd23;

    logic [CW-1:0]                         cnt, cnt_nxt;
    logic [IW-1:0]                         idx, idx_nxt;
    logic [FW-1:0]                         frame_cnt, frame_cnt_nxt;
    logic                                  blink_phase, blink_phase_nxt;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]     shadow, shadow_nxt;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]     load_c;
    logic                                  tick_c, boundary_c;
    logic [CODE_W-1:0]                     digit_code_c;
    logic [NUM_DIGITS-1:0]                 an_n_c;
`ifdef LEADING_ZERO_BLANK_EN
    logic                                  lead_c;
`endif

    // Shadow load value, optionally with leading zeros replaced by blank (digit 0 always kept).
    always_comb begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            load_c[i] = digits_in[CODE_W*i +: CODE_W];
        end
`ifdef LEADING_ZERO_BLANK_EN
        lead_c = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            if (lead_c && (load_c[i] == '0)) begin
                load_c[i] = BLANK;
            end else begin
                lead_c = 1'b0;
            end
        end
`endif
    end

    // Next-state: prescaler, digit index, frame counter, blink phase, shadow.
    always_comb begin
        tick_c          = (cnt == CW'(SCAN_DIV - 1));
        boundary_c      = tick_c && (idx == IW'(NUM_DIGITS - 1));
        cnt_nxt         = tick_c ? '0 : cnt + CW'(1);
        idx_nxt         = idx;
        frame_cnt_nxt   = frame_cnt;
        blink_phase_nxt = blink_phase;
        shadow_nxt      = shadow;
        if (tick_c) begin
            idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
        end
        if (boundary_c) begin
            shadow_nxt = load_c;
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_nxt   = '0;
                blink_phase_nxt = ~blink_phase;
            end else begin
                frame_cnt_nxt = frame_cnt + FW'(1);
            end
        end
    end

    // Output values from current state; cnt==0 is the anti-ghosting guard slot.
    always_comb begin
        digit_code_c = shadow[idx];
        an_n_c       = '1;
        if (blink_mask[idx] && blink_phase) begin
            digit_code_c = BLANK;
        end
        if (enable && (cnt != '0)) begin
            an_n_c = ~(NUM_DIGITS'(1) << idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            shadow      <= {NUM_DIGITS{BLANK}};
            digit_code  <= BLANK;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            frame_cnt   <= frame_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            shadow      <= shadow_nxt;
            digit_code  <= digit_code_c;
            an_n        <= an_n_c;
            frame_start <= boundary_c;
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver (4 digits, 4-cycle slots, 2-frame blink half-period).
module tb_display_scan_driver;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned BF = 2;
    localparam logic [4:0]  BL = 5'd23;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [5*ND-1:0] digits_in;
    logic [ND-1:0]   blink_mask;
    logic [4:0]      digit_code;
    logic [ND-1:0]   an_n;
    logic            frame_start;

    int n_assert = 0;
    int n_fail   = 0;
    int frame_no = 0;

    initial forever #5 clk = ~clk;

    display_scan_driver #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .digits_in  (digits_in),
        .blink_mask (blink_mask),
        .digit_code (digit_code),
        .an_n       (an_n),
        .frame_start(frame_start)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One 16-cycle frame; codes packed {d3,d2,d1,d0}; optional mid-frame digits/enable changes after cycle j.
    task automatic run_frame(input logic [19:0] codes, input int chg_j, input logic [19:0] chg_val,
                             input int off_j, input int on_j);
        for (int j = 0; j < 16; j++) begin
            logic [4:0] ec;
            logic [3:0] ea;
            int         s;
            step();
            s  = j / 4;
            ec = codes[5*s +: 5];
            if ((j % 4 == 0) || (j > off_j && j <= on_j)) ea = 4'hF;
            else ea = 4'(~(4'b0001 << s));
            chk($sformatf("code f%0d c%0d", frame_no, j), 32'(digit_code), 32'(ec));
            chk($sformatf("an_n f%0d c%0d", frame_no, j), 32'(an_n), 32'(ea));
            chk($sformatf("fstart f%0d c%0d", frame_no, j), 32'(frame_start), (j == 15) ? 32'd1 : 32'd0);
            if (j == chg_j) digits_in = chg_val;
            if (j == off_j) enable = 1'b0;
            if (j == on_j)  enable = 1'b1;
        end
        frame_no++;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        digits_in  = '0;
        blink_mask = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rst code %0d", k), 32'(digit_code), 32'd23);
            chk($sformatf("rst an_n %0d", k), 32'(an_n), 32'hF);
            chk($sformatf("rst fstart %0d", k), 32'(frame_start), 32'd0);
        end
        rst_n     = 1'b1;
        digits_in = {5'd4, 5'd3, 5'd2, 5'd1};

        run_frame({BL, BL, BL, BL}, -1, '0, -1, -1);
        run_frame({5'd4, 5'd3, 5'd2, 5'd1}, -1, '0, -1, -1);
        run_frame({5'd4, 5'd3, 5'd2, 5'd1}, 5, {5'd9, 5'd9, 5'd9, 5'd9}, -1, -1);
        run_frame({5'd9, 5'd9, 5'd9, 5'd9}, -1, '0, -1, -1);

        blink_mask = 4'b0011;
        digits_in  = {5'd8, 5'd7, 5'd6, 5'd5};
        run_frame({5'd9, 5'd9, 5'd9, 5'd9}, -1, '0, -1, -1);
        run_frame({5'd8, 5'd7, 5'd6, 5'd5}, -1, '0, -1, -1);
        run_frame({5'd8, 5'd7, BL, BL}, -1, '0, -1, -1);
        run_frame({5'd8, 5'd7, BL, BL}, -1, '0, -1, -1);
        run_frame({5'd8, 5'd7, 5'd6, 5'd5}, -1, '0, -1, -1);

        blink_mask = '0;
        digits_in  = {5'd31, 5'd24, 5'd0, 5'd3};
        run_frame({5'd8, 5'd7, 5'd6, 5'd5}, -1, '0, 6, 10);

        digits_in = {5'd0, 5'd0, 5'd0, 5'd7};
        run_frame({5'd31, 5'd24, 5'd0, 5'd3}, -1, '0, -1, -1);

        digits_in = {5'd0, 5'd5, 5'd0, 5'd0};
`ifdef LEADING_ZERO_BLANK_EN
        run_frame({BL, BL, BL, 5'd7}, -1, '0, -1, -1);
        run_frame({BL, 5'd5, 5'd0, 5'd0}, -1, '0, -1, -1);
`else
        run_frame({5'd0, 5'd0, 5'd0, 5'd7}, -1, '0, -1, -1);
        run_frame({5'd0, 5'd5, 5'd0, 5'd0}, -1, '0, -1, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
